bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

Sequential 4-digit BCD to 14-bit binary converter using the reverse double-dabble algorithm: shift right one bit per cycle, then subtract 3 from any BCD nibble ≥ 8. It is the inverse of the stopwatch's `doubleDabble` binary-to-BCD path. It turns user-entered or preset BCD times (0000–9999) back into binary counter values. A start/ready handshake makes it usable by a control FSM and lets a bench chain it back-to-back with `doubleDabble`.

## Interface
- No parameters. Widths are fixed: 16-bit BCD in, 14-bit binary out.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request conversion. Sampled only in IDLE or DONE.
- `bcd` input 16: four BCD digits. [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones. Captured on the accepting edge.
- `bin` output 14: converted value, registered. Valid while `ready`=1.
- `ready` output 1: result valid. Held high until the next accepted `start` or `rst`.
- `busy` output 1: conversion in progress.
- `err` output 1: the last captured `bcd` had a nibble > 9. Valid while `ready`=1.

## Operation
- **Reset values:** state=IDLE, `bin`=0, `ready`=0, `busy`=0, `err`=0, internal shift register=0, iteration counter=0.
- **States:**
  - IDLE: wait for `start`.
  - CONVERT: 14 shift iterations, tracked by a 4-bit counter running 0..13.
  - DONE: result held.
- **Start acceptance:** `start`=1 in IDLE or DONE is accepted on that edge (E0).
  - If all nibbles ≤ 9:
    - Load the 30-bit register {`bcd`, 14'b0}.
    - Clear the counter.
    - `ready`←0, `busy`←1, `err`←0.
    - Go to CONVERT.
  - If any nibble > 9:
    - `err`←1, `bin`←0, `ready`←1, `busy`←0.
    - Go to DONE. No conversion runs.
- **CONVERT iteration (one per cycle):**
  - Logical right shift of the 30-bit register by 1.
  - Then, independently for each of the four nibbles in bits [29:14], if the nibble ≥ 8, subtract 3.
  - Apply the correction to the post-shift value in the same cycle.
- **Last iteration:** on the iteration with counter=13:
  - `bin`← low 14 bits of the post-shift, post-correct value.
  - `ready`←1, `busy`←0.
  - Go to DONE.
- **Start while busy:** `start` during CONVERT is ignored. No restart, no queuing.
- **DONE hold:** `bin`, `err` and `ready` are held until a new `start` is accepted or `rst`.
  - A new start in DONE drops `ready` on the accepting edge.
- **Range:** the maximum input 9999 gives 14'h270F, which fits 14 bits. Overflow is impossible.
- **Mid-operation reset:** `rst` has priority over everything in every state, including mid-CONVERT. Next cycle all outputs are at reset values.

## Timing
- **Valid input:** `start` accepted at edge E0. Shifts occur at E1..E14. `ready`=1 and `bin` valid after E14.
  - Latency is 14 cycles. `busy`=1 after E0 through E13, inclusive.
- **Invalid input:** `ready`=1, `err`=1, `bin`=0 after E0. Latency is 1 cycle.
- **Throughput:** one conversion per 15 cycles when `start` is held high, since a new start is accepted in DONE on the cycle after `ready` rises.
- `bcd` need only be stable at E0. Later changes have no effect.
- **Outputs:** all registered. No combinational path from inputs to outputs.

## Test plan
- **Reset and zero:** assert `rst` 2 cycles, then `start` with `bcd`=16'h0000.
  - After reset: `bin`=0, `ready`=0, `busy`=0, `err`=0.
  - After conversion: `ready` rises exactly 14 cycles after acceptance, `bin`=0, `err`=0.
- **Corner values:**
  - `bcd`=16'h9999 → `bin`=14'd9999.
  - `bcd`=16'h1234 → `bin`=14'd1234, 14-cycle latency.
  - `bcd`=16'h0008 → `bin`=14'd8.
- **Invalid digit:** `bcd`=16'h12A4 → one cycle after acceptance, `err`=1, `ready`=1, `bin`=0.
  - A following valid `start` with 16'h0042 → `err`=0, `bin`=42.
- **Busy protection:**
  - `start` with 16'h0500, then at cycle 5 pulse `start` with 16'h0777 → `bin`=500, `ready` at cycle 14, second request ignored.
  - Holding `start` high with 16'h0001 → `ready` pulses with period 15.
- **Reset mid-operation:** `start` 16'h4321, assert `rst` at cycle 7.
  - Next cycle: all outputs at reset values, state IDLE.
  - A new start with 16'h0100 → `bin`=100 after 14 cycles.
- **Exhaustive sweep:** for N = 0..9999, drive the BCD of N, wait for `ready`, check `bin`==N and `err`=0.
  - Optionally loop `bin` through `doubleDabble` and back, checking a round-trip match.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// One right shift plus per-nibble "subtract 3 if >= 8" correction per cycle, 14 cycles per result.
module bcd_to_binary (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bcd,
    output logic [13:0] bin,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned BCD_W   = 16;
    localparam int unsigned BIN_W   = 14;
    localparam int unsigned SR_W    = BCD_W + BIN_W;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DIGITS  = 4;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   sr_next_c;
    logic              bcd_bad_c;

    // Flags any input digit outside 0..9.
    always_comb begin
        bcd_bad_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                bcd_bad_c = 1'b1;
            end
        end
    end

    // One iteration: shift right, then pull each BCD nibble back into range.
    always_comb begin
        sr_next_c = sr >> 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sr_next_c[int'(BIN_W) + 4*i +: 4] >= 4'd8) begin
                sr_next_c[int'(BIN_W) + 4*i +: 4] = sr_next_c[int'(BIN_W) + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            bin   <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (bcd_bad_c) begin
                            // Bad digit: report immediately, no conversion.
                            err   <= 1'b1;
                            bin   <= '0;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            sr    <= {bcd, BIN_W'(0)};
                            cnt   <= '0;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                            state <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    sr  <= sr_next_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        bin   <= sr_next_c[BIN_W-1:0];
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed vector table, handshake corner
// sequences, and a strided sweep of 0..9999 against an arithmetic BCD model.
module tb_bcd_to_binary;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd;
    logic [13:0] bin;
    logic        ready;
    logic        busy;
    logic        err;

    int n_checks;
    int n_fail;

    bcd_to_binary dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
        end
    endtask

    // Advance one rising edge; inputs driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] v;
        v = {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
        return v;
    endfunction

    // Issue one start and check latency (edges after acceptance), result and flags.
    task automatic run_conv(input logic [15:0] v, input logic [13:0] exp_bin,
                            input logic exp_err, input int exp_lat);
        int lat;
        start = 1'b1;
        bcd   = v;
        step();
        start = 1'b0;
        bcd   = 16'hFFFF;
        if (!exp_err) check("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!ready && lat < 40) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("bin", 32'(bin), 32'(exp_bin));
        check("err", 32'(err), 32'(exp_err));
        check("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int rises[$];
        logic prev;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{16'h0000, 14'd0,    1'b0, 14};
        vecs[1]  = '{16'h9999, 14'd9999, 1'b0, 14};
        vecs[2]  = '{16'h1234, 14'd1234, 1'b0, 14};
        vecs[3]  = '{16'h0008, 14'd8,    1'b0, 14};
        vecs[4]  = '{16'h12A4, 14'd0,    1'b1, 0};
        vecs[5]  = '{16'h0042, 14'd42,   1'b0, 14};
        vecs[6]  = '{16'h0099, 14'd99,   1'b0, 14};
        vecs[7]  = '{16'h1000, 14'd1000, 1'b0, 14};
        vecs[8]  = '{16'h00F0, 14'd0,    1'b1, 0};
        vecs[9]  = '{16'h9000, 14'd9000, 1'b0, 14};
        vecs[10] = '{16'hA000, 14'd0,    1'b1, 0};
        vecs[11] = '{16'h0010, 14'd10,   1'b0, 14};
        vecs[12] = '{16'h8888, 14'd8888, 1'b0, 14};

        rst   = 1'b1;
        start = 1'b0;
        bcd   = 16'h0000;
        step();
        step();
        check("rst_bin",   32'(bin),   32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            run_conv(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].lat);
        end

        // Result held in DONE while no start is presented.
        step();
        step();
        step();
        check("done_hold_ready", 32'(ready), 32'd1);
        check("done_hold_bin",   32'(bin),   32'd8888);

        // A second start during CONVERT must be ignored.
        start = 1'b1;
        bcd   = 16'h0500;
        step();
        start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        start = 1'b1;
        bcd   = 16'h0777;
        step();
        start = 1'b0;
        bcd   = 16'h0000;
        lat = 5;
        while (!ready && lat < 40) begin
            step();
            lat++;
        end
        check("busy_prot_latency", 32'(lat), 32'd14);
        check("busy_prot_bin",     32'(bin), 32'd500);
        step();
        check("busy_prot_no_restart", 32'(busy), 32'd0);

        // Start held high: ready rises every 15 cycles.
        start = 1'b1;
        bcd   = 16'h0001;
        prev  = ready;
        for (int c = 0; c < 50; c++) begin
            step();
            if (ready && !prev) rises.push_back(c);
            prev = ready;
        end
        start = 1'b0;
        check("held_rise_count_ge2", 32'(rises.size() >= 2), 32'd1);
        if (rises.size() >= 2) check("held_period", 32'(rises[1] - rises[0]), 32'd15);
        check("held_bin", 32'(bin), 32'd1);
        while (!ready && lat < 80) begin
            step();
            lat++;
        end

        // Reset mid-conversion.
        start = 1'b1;
        bcd   = 16'h4321;
        step();
        start = 1'b0;
        for (int k = 1; k < 7; k++) step();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_bin",   32'(bin),   32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_busy",  32'(busy),  32'd0);
        check("mid_rst_err",   32'(err),   32'd0);
        step();
        check("mid_rst_idle_busy", 32'(busy), 32'd0);
        run_conv(16'h0100, 14'd100, 1'b0, 14);

        // Strided sweep over the full input range.
        for (int n = 0; n < 10000; n += 7) begin
            run_conv(to_bcd(n), 14'(n), 1'b0, 14);
        end
        run_conv(to_bcd(9998), 14'd9998, 1'b0, 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
